// File: rtl/yutorina_pipe_ctrl.sv
// Yutorina pipeline controller: stalls, flushes, commit-stage traps, SPRs.
// Optional external interrupt support is enabled by YUTORINA_IRQ_EN.
module yutorina_pipe_ctrl (
  input  logic        clk,
  input  logic        reset_,
  input  logic        if_busy,
  input  logic        mem_busy,
  input  logic        ld_hazard,
  input  logic        id_br_taken,
  input  logic [29:0] mem_pc,
  input  logic [2:0]  mem_exp_code,
  input  logic [1:0]  mem_ctrl_op,
  input  logic [4:0]  mem_spr_addr,
  input  logic [31:0] mem_spr_data,
  input  logic [4:0]  id_spr_addr,
`ifdef YUTORINA_IRQ_EN
  input  logic        irq,
`endif
  output logic [31:0] spr_r_data,
  output logic        mode,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        mem_flush,
  output logic [29:0] new_pc,
  output logic        pc_load
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    EXC  = 2'd1,
    ERET = 2'd2
  } state_t;

  localparam logic [1:0] OP_SSR  = 2'd2;
  localparam logic [1:0] OP_ERET = 2'd3;
  localparam logic [2:0] EXP_IRQ = 3'd4;

  state_t      state;
  state_t      state_nxt;
  logic        ie;
  logic        pmode;
  logic        pie;
  logic [29:0] epc;
  logic [2:0]  cause;
  logic [29:0] vector;

  logic        irq_take;
  logic        exc_take;
  logic [2:0]  exc_code;
  logic        eret_take;
  logic        ssr_take;

  // A trap at commit wins over ERET and SSR; nothing commits while busy.
  always_comb begin
    irq_take = 1'b0;
`ifdef YUTORINA_IRQ_EN
    irq_take = irq && ie && (mem_exp_code == 3'd0);
`endif
    exc_take  = (state == RUN) && !mem_busy &&
                ((mem_exp_code != 3'd0) || irq_take);
    exc_code  = (mem_exp_code != 3'd0) ? mem_exp_code : EXP_IRQ;
    eret_take = (state == RUN) && !mem_busy && !exc_take &&
                (mem_ctrl_op == OP_ERET);
    ssr_take  = (state == RUN) && !mem_busy && !exc_take &&
                (mem_ctrl_op == OP_SSR);
  end

  // Next-state and stage control; redirect cycles depend on state only.
  always_comb begin
    state_nxt = state;
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    pc_load   = 1'b0;
    new_pc    = 30'd0;
    unique case (state)
      EXC: begin
        pc_load   = 1'b1;
        new_pc    = vector;
        if_flush  = 1'b1;
        id_flush  = 1'b1;
        ex_flush  = 1'b1;
        mem_flush = 1'b1;
        state_nxt = RUN;
      end
      ERET: begin
        pc_load   = 1'b1;
        new_pc    = epc;
        if_flush  = 1'b1;
        id_flush  = 1'b1;
        ex_flush  = 1'b1;
        mem_flush = 1'b1;
        state_nxt = RUN;
      end
      default: begin
        if (mem_busy) begin
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_stall  = 1'b1;
          mem_stall = 1'b1;
        end else if (if_busy) begin
          if_stall = 1'b1;
          id_flush = 1'b1;
        end else if (ld_hazard) begin
          if_stall = 1'b1;
          id_stall = 1'b1;
          ex_flush = 1'b1;
        end else if (id_br_taken) begin
          id_flush = 1'b1;
        end
        if (exc_take)
          state_nxt = EXC;
        else if (eret_take)
          state_nxt = ERET;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)
      state <= RUN;
    else
      state <= state_nxt;
  end

  // SPR updates from traps, ERET restore and SSR writes.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      mode   <= 1'b0;
      ie     <= 1'b0;
      pmode  <= 1'b0;
      pie    <= 1'b0;
      epc    <= 30'd0;
      cause  <= 3'd0;
      vector <= 30'd0;
    end else if (exc_take) begin
      epc   <= mem_pc;
      cause <= exc_code;
      pie   <= ie;
      pmode <= mode;
      mode  <= 1'b0;
      ie    <= 1'b0;
    end else if (state == ERET) begin
      ie   <= pie;
      mode <= pmode;
    end else if (ssr_take) begin
      unique case (mem_spr_addr)
        5'd0: begin
          mode  <= mem_spr_data[0];
          ie    <= mem_spr_data[1];
          pmode <= mem_spr_data[2];
          pie   <= mem_spr_data[3];
        end
        5'd1:    epc    <= mem_spr_data[29:0];
        5'd2:    cause  <= mem_spr_data[2:0];
        5'd3:    vector <= mem_spr_data[29:0];
        default: ;
      endcase
    end
  end

  // Combinational SPR read port for LSR.
  always_comb begin
    spr_r_data = 32'd0;
    unique case (id_spr_addr)
      5'd0:    spr_r_data = {28'd0, pie, pmode, ie, mode};
      5'd1:    spr_r_data = {2'd0, epc};
      5'd2:    spr_r_data = {29'd0, cause};
      5'd3:    spr_r_data = {2'd0, vector};
      default: spr_r_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_yutorina_pipe_ctrl.sv
// Directed bench for yutorina_pipe_ctrl.
// Define YUTORINA_IRQ_EN to also exercise the interrupt path.
module tb_yutorina_pipe_ctrl;

  logic        clk;
  logic        reset_;
  logic        if_busy;
  logic        mem_busy;
  logic        ld_hazard;
  logic        id_br_taken;
  logic [29:0] mem_pc;
  logic [2:0]  mem_exp_code;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_spr_addr;
  logic [31:0] mem_spr_data;
  logic [4:0]  id_spr_addr;
  logic        irq;
  logic [31:0] spr_r_data;
  logic        mode;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic [29:0] new_pc;
  logic        pc_load;

  int pass_cnt = 0;
  int total_cnt = 0;

  yutorina_pipe_ctrl dut (
    .clk          (clk),
    .reset_       (reset_),
    .if_busy      (if_busy),
    .mem_busy     (mem_busy),
    .ld_hazard    (ld_hazard),
    .id_br_taken  (id_br_taken),
    .mem_pc       (mem_pc),
    .mem_exp_code (mem_exp_code),
    .mem_ctrl_op  (mem_ctrl_op),
    .mem_spr_addr (mem_spr_addr),
    .mem_spr_data (mem_spr_data),
    .id_spr_addr  (id_spr_addr),
`ifdef YUTORINA_IRQ_EN
    .irq          (irq),
`endif
    .spr_r_data   (spr_r_data),
    .mode         (mode),
    .if_stall     (if_stall),
    .id_stall     (id_stall),
    .ex_stall     (ex_stall),
    .mem_stall    (mem_stall),
    .if_flush     (if_flush),
    .id_flush     (id_flush),
    .ex_flush     (ex_flush),
    .mem_flush    (mem_flush),
    .new_pc       (new_pc),
    .pc_load      (pc_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [3:0] stalls = {if_stall, id_stall, ex_stall, mem_stall};
  wire [3:0] flushes = {if_flush, id_flush, ex_flush, mem_flush};

  task automatic clear();
    if_busy      = 1'b0;
    mem_busy     = 1'b0;
    ld_hazard    = 1'b0;
    id_br_taken  = 1'b0;
    mem_pc       = 30'd0;
    mem_exp_code = 3'd0;
    mem_ctrl_op  = 2'd0;
    mem_spr_addr = 5'd0;
    mem_spr_data = 32'd0;
    id_spr_addr  = 5'd0;
    irq          = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ssr(input logic [4:0] a, input logic [31:0] d);
    mem_ctrl_op  = 2'd2;
    mem_spr_addr = a;
    mem_spr_data = d;
    tick();
    clear();
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    clear();
    #12;
    total_cnt++;
    if ({stalls, flushes, pc_load, mode} !== 10'd0 || new_pc !== 30'd0)
      $display("FAIL reset_outs: got st=%b fl=%b pl=%b m=%b pc=%h want 0",
               stalls, flushes, pc_load, mode, new_pc);
    else pass_cnt++;
    reset_ = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      id_spr_addr = 5'(i);
      #1;
      total_cnt++;
      if (spr_r_data !== 32'd0)
        $display("FAIL reset_spr%0d: got %h want 0", i, spr_r_data);
      else pass_cnt++;
    end
    clear();
  endtask

  task automatic test_exception();
    ssr(5'd3, 32'h100);
    id_spr_addr = 5'd3;
    #1;
    total_cnt++;
    if (spr_r_data !== 32'h100)
      $display("FAIL vector_wr: got %h want 100", spr_r_data);
    else pass_cnt++;
    mem_exp_code = 3'd3;
    mem_pc = 30'h40;
    #1;
    total_cnt++;
    if (pc_load !== 1'b0)
      $display("FAIL exc_detect_pl: got %b want 0", pc_load);
    else pass_cnt++;
    tick();
    clear();
    total_cnt++;
    if (pc_load !== 1'b1 || new_pc !== 30'h100 ||
        flushes !== 4'hf || stalls !== 4'h0)
      $display("FAIL exc_redirect: got pl=%b pc=%h fl=%b st=%b want 1 100 1111 0000",
               pc_load, new_pc, flushes, stalls);
    else pass_cnt++;
    id_spr_addr = 5'd1;
    #1;
    total_cnt++;
    if (spr_r_data !== 32'h40)
      $display("FAIL exc_epc: got %h want 40", spr_r_data);
    else pass_cnt++;
    id_spr_addr = 5'd2;
    #1;
    total_cnt++;
    if (spr_r_data !== 32'd3 || mode !== 1'b0)
      $display("FAIL exc_cause: got %h m=%b want 3 m=0", spr_r_data, mode);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (pc_load !== 1'b0 || flushes !== 4'h0)
      $display("FAIL exc_return_run: got pl=%b fl=%b want 0", pc_load, flushes);
    else pass_cnt++;
  endtask

  task automatic test_eret();
    ssr(5'd0, 32'h1);
    total_cnt++;
    if (mode !== 1'b1)
      $display("FAIL user_mode: got %b want 1", mode);
    else pass_cnt++;
    mem_exp_code = 3'd3;
    mem_pc = 30'h40;
    tick();
    clear();
    id_spr_addr = 5'd0;
    #1;
    total_cnt++;
    if (mode !== 1'b0 || spr_r_data !== 32'h4)
      $display("FAIL trap_status: got m=%b st=%h want m=0 st=4",
               mode, spr_r_data);
    else pass_cnt++;
    tick();
    ssr(5'd1, 32'h41);
    mem_ctrl_op = 2'd3;
    #1;
    total_cnt++;
    if (pc_load !== 1'b0)
      $display("FAIL eret_detect_pl: got %b want 0", pc_load);
    else pass_cnt++;
    tick();
    clear();
    total_cnt++;
    if (pc_load !== 1'b1 || new_pc !== 30'h41 || flushes !== 4'hf)
      $display("FAIL eret_redirect: got pl=%b pc=%h fl=%b want 1 41 1111",
               pc_load, new_pc, flushes);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (mode !== 1'b1 || pc_load !== 1'b0)
      $display("FAIL eret_mode: got m=%b pl=%b want m=1 pl=0", mode, pc_load);
    else pass_cnt++;
    ssr(5'd0, 32'h0);
  endtask

  task automatic test_busy();
    mem_busy = 1'b1;
    mem_exp_code = 3'd1;
    mem_pc = 30'h10;
    id_spr_addr = 5'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (stalls !== 4'hf || pc_load !== 1'b0 || spr_r_data !== 32'h41)
        $display("FAIL busy_win%0d: got st=%b pl=%b epc=%h want 1111 0 41",
                 i, stalls, pc_load, spr_r_data);
      else pass_cnt++;
      tick();
    end
    mem_busy = 1'b0;
    #1;
    total_cnt++;
    if (pc_load !== 1'b0 || stalls !== 4'h0)
      $display("FAIL busy_release: got pl=%b st=%b want 0 0000", pc_load, stalls);
    else pass_cnt++;
    tick();
    clear();
    id_spr_addr = 5'd2;
    #1;
    total_cnt++;
    if (pc_load !== 1'b1 || new_pc !== 30'h100 || spr_r_data !== 32'd1)
      $display("FAIL busy_redirect: got pl=%b pc=%h cause=%h want 1 100 1",
               pc_load, new_pc, spr_r_data);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_hazard();
    ld_hazard = 1'b1;
    id_br_taken = 1'b1;
    #1;
    total_cnt++;
    if (stalls !== 4'b1100 || flushes !== 4'b0010)
      $display("FAIL ld_hazard_br: got st=%b fl=%b want 1100 0010",
               stalls, flushes);
    else pass_cnt++;
    if_busy = 1'b1;
    #1;
    total_cnt++;
    if (stalls !== 4'b1000 || flushes !== 4'b0100)
      $display("FAIL if_busy: got st=%b fl=%b want 1000 0100", stalls, flushes);
    else pass_cnt++;
    clear();
    id_br_taken = 1'b1;
    #1;
    total_cnt++;
    if (stalls !== 4'b0000 || flushes !== 4'b0100 || pc_load !== 1'b0)
      $display("FAIL branch: got st=%b fl=%b pl=%b want 0000 0100 0",
               stalls, flushes, pc_load);
    else pass_cnt++;
    clear();
  endtask

  task automatic test_priority();
    mem_exp_code = 3'd2;
    mem_pc = 30'h50;
    mem_ctrl_op = 2'd2;
    mem_spr_addr = 5'd3;
    mem_spr_data = 32'h200;
    tick();
    mem_exp_code = 3'd3;
    mem_pc = 30'h99;
    mem_ctrl_op = 2'd2;
    #1;
    total_cnt++;
    if (pc_load !== 1'b1 || new_pc !== 30'h100 || stalls !== 4'h0)
      $display("FAIL exc_over_ssr: got pl=%b pc=%h st=%b want 1 100 0000",
               pc_load, new_pc, stalls);
    else pass_cnt++;
    tick();
    clear();
    id_spr_addr = 5'd1;
    #1;
    total_cnt++;
    if (spr_r_data !== 32'h50 || pc_load !== 1'b0)
      $display("FAIL exc_in_exc_ignored: got epc=%h pl=%b want 50 0",
               spr_r_data, pc_load);
    else pass_cnt++;
    ssr(5'd5, 32'h1234);
    id_spr_addr = 5'd5;
    #1;
    total_cnt++;
    if (spr_r_data !== 32'd0)
      $display("FAIL spr_oob: got %h want 0", spr_r_data);
    else pass_cnt++;
    clear();
  endtask

  task automatic test_irq();
`ifdef YUTORINA_IRQ_EN
    irq = 1'b1;
    mem_pc = 30'h80;
    tick();
    total_cnt++;
    if (pc_load !== 1'b0)
      $display("FAIL irq_ie0: got pl=%b want 0", pc_load);
    else pass_cnt++;
    clear();
    ssr(5'd0, 32'h2);
    irq = 1'b1;
    mem_pc = 30'h80;
    tick();
    clear();
    id_spr_addr = 5'd2;
    #1;
    total_cnt++;
    if (pc_load !== 1'b1 || spr_r_data !== 32'd4)
      $display("FAIL irq_cause: got pl=%b cause=%h want 1 4",
               pc_load, spr_r_data);
    else pass_cnt++;
    id_spr_addr = 5'd1;
    #1;
    total_cnt++;
    if (spr_r_data !== 32'h80)
      $display("FAIL irq_epc: got %h want 80", spr_r_data);
    else pass_cnt++;
    id_spr_addr = 5'd0;
    #1;
    total_cnt++;
    if (spr_r_data !== 32'h8)
      $display("FAIL irq_status: got %h want 8", spr_r_data);
    else pass_cnt++;
    tick();
`else
    ssr(5'd0, 32'h2);
    irq = 1'b1;
    mem_pc = 30'h80;
    tick();
    total_cnt++;
    if (pc_load !== 1'b0)
      $display("FAIL ie_no_effect: got pl=%b want 0", pc_load);
    else pass_cnt++;
`endif
    clear();
  endtask

  task automatic test_async_reset();
    mem_exp_code = 3'd4;
    tick();
    clear();
    #1;
    reset_ = 1'b0;
    #1;
    id_spr_addr = 5'd3;
    #1;
    total_cnt++;
    if (pc_load !== 1'b0 || flushes !== 4'h0 || spr_r_data !== 32'd0)
      $display("FAIL async_reset: got pl=%b fl=%b vec=%h want 0 0000 0",
               pc_load, flushes, spr_r_data);
    else pass_cnt++;
    reset_ = 1'b1;
    tick();
  endtask

  initial begin
    clear();
    test_reset();
    test_exception();
    test_eret();
    test_busy();
    test_hazard();
    test_priority();
    test_irq();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
